// File: rtl/usb_tx_line_encoder.sv
// USB transmit line encoder: bit stuffing, NRZI, differential D+/D- drive and EOP.
// Consumes one serial bit per bit_strobe and drives registered line levels.
module usb_tx_line_encoder #(
  parameter int RUN_LEN      = 6,
  parameter int CNT_W        = 4,
  parameter int EOP_SE0_BITS = 2
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             bit_strobe,
  input  logic             tx_start,
  input  logic             d_in,
  input  logic             eop_req,
  input  logic             stuff_en,
  output logic             pause,
  output logic             tx_active,
  output logic             eop_done,
  output logic             d_plus,
  output logic             d_minus,
  output logic [CNT_W-1:0] ones_cnt
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_DATA    = 3'd1,
    S_STUFF   = 3'd2,
    S_EOP_SE0 = 3'd3,
    S_EOP_J   = 3'd4
  } state_e;

  localparam logic [CNT_W-1:0] RUN_LEN_C = CNT_W'(RUN_LEN);
  localparam logic [CNT_W-1:0] ONES_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] ONES_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [1:0]       SE0_LAST  = 2'(EOP_SE0_BITS);

  state_e           state_q, state_d;
  logic             level_q, level_d;
  logic [CNT_W-1:0] ones_q, ones_d;
  logic [1:0]       se0_q, se0_d;
  logic             pause_q, pause_d;
  logic             tx_active_q, tx_active_d;
  logic             eop_done_q, eop_done_d;
  logic             dp_q, dp_d;
  logic             dm_q, dm_d;

  // State and registered line/status outputs.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= S_IDLE;
      level_q     <= 1'b1;
      ones_q      <= '0;
      se0_q       <= 2'd0;
      pause_q     <= 1'b0;
      tx_active_q <= 1'b0;
      eop_done_q  <= 1'b0;
      dp_q        <= 1'b1;
      dm_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      level_q     <= level_d;
      ones_q      <= ones_d;
      se0_q       <= se0_d;
      pause_q     <= pause_d;
      tx_active_q <= tx_active_d;
      eop_done_q  <= eop_done_d;
      dp_q        <= dp_d;
      dm_q        <= dm_d;
    end
  end

  // Next-state logic; line values are computed from the next NRZI level so they land one cycle after the strobe.
  always_comb begin
    state_d     = state_q;
    level_d     = level_q;
    ones_d      = ones_q;
    se0_d       = se0_q;
    pause_d     = pause_q;
    tx_active_d = tx_active_q;
    eop_done_d  = 1'b0;
    dp_d        = dp_q;
    dm_d        = dm_q;

    case (state_q)
      S_IDLE: begin
        dp_d = 1'b1;
        dm_d = 1'b0;
        // A start landing on the eop_done cycle belongs to the packet just finished.
        if (tx_start && !eop_done_q) begin
          state_d     = S_DATA;
          tx_active_d = 1'b1;
          ones_d      = '0;
          level_d     = 1'b1;
        end else begin
          tx_active_d = 1'b0;
        end
      end

      S_DATA: begin
        if (bit_strobe) begin
          if (eop_req) begin
            state_d = S_EOP_SE0;
            se0_d   = 2'd1;
            ones_d  = '0;
            dp_d    = 1'b0;
            dm_d    = 1'b0;
          end else begin
            if (!d_in) begin
              level_d = ~level_q;
              ones_d  = '0;
            end else if (ones_q != ONES_MAX) begin
              ones_d = ones_q + ONES_ONE;
            end else begin
              ones_d = ones_q;
            end
            if (stuff_en && (ones_d == RUN_LEN_C)) begin
              state_d = S_STUFF;
              pause_d = 1'b1;
            end else begin
              state_d = S_DATA;
            end
            dp_d = level_d;
            dm_d = ~level_d;
          end
        end else begin
          state_d = S_DATA;
        end
      end

      S_STUFF: begin
        if (bit_strobe) begin
          level_d = ~level_q;
          ones_d  = '0;
          pause_d = 1'b0;
          state_d = S_DATA;
          dp_d    = level_d;
          dm_d    = ~level_d;
        end else begin
          state_d = S_STUFF;
        end
      end

      S_EOP_SE0: begin
        if (bit_strobe) begin
          if (se0_q == SE0_LAST) begin
            state_d = S_EOP_J;
            dp_d    = 1'b1;
            dm_d    = 1'b0;
          end else begin
            se0_d = se0_q + 2'd1;
            dp_d  = 1'b0;
            dm_d  = 1'b0;
          end
        end else begin
          state_d = S_EOP_SE0;
        end
      end

      S_EOP_J: begin
        if (bit_strobe) begin
          state_d     = S_IDLE;
          tx_active_d = 1'b0;
          eop_done_d  = 1'b1;
          dp_d        = 1'b1;
          dm_d        = 1'b0;
        end else begin
          state_d = S_EOP_J;
        end
      end

      default: begin
        state_d     = S_IDLE;
        level_d     = 1'b1;
        ones_d      = '0;
        pause_d     = 1'b0;
        tx_active_d = 1'b0;
        dp_d        = 1'b1;
        dm_d        = 1'b0;
      end
    endcase
  end

  assign pause     = pause_q;
  assign tx_active = tx_active_q;
  assign eop_done  = eop_done_q;
  assign d_plus    = dp_q;
  assign d_minus   = dm_q;
  assign ones_cnt  = ones_q;

endmodule

// File: tb/tb_usb_tx_line_encoder.sv
// Directed bench for usb_tx_line_encoder: default instance plus a RUN_LEN=3 / EOP_SE0_BITS=3 instance.
module tb_usb_tx_line_encoder;

  localparam logic [1:0] LJ   = 2'b10;
  localparam logic [1:0] LK   = 2'b01;
  localparam logic [1:0] LSE0 = 2'b00;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic bit_strobe = 1'b0;
  logic tx_start = 1'b0;
  logic d_in = 1'b0;
  logic eop_req = 1'b0;
  logic stuff_en = 1'b1;

  logic a_pause, a_act, a_done, a_dp, a_dm;
  logic [3:0] a_ones;
  logic b_pause, b_act, b_done, b_dp, b_dm;
  logic [3:0] b_ones;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  usb_tx_line_encoder dut_a (
    .clk(clk), .n_rst(n_rst), .bit_strobe(bit_strobe), .tx_start(tx_start),
    .d_in(d_in), .eop_req(eop_req), .stuff_en(stuff_en),
    .pause(a_pause), .tx_active(a_act), .eop_done(a_done),
    .d_plus(a_dp), .d_minus(a_dm), .ones_cnt(a_ones)
  );

  usb_tx_line_encoder #(.RUN_LEN(3), .CNT_W(4), .EOP_SE0_BITS(3)) dut_b (
    .clk(clk), .n_rst(n_rst), .bit_strobe(bit_strobe), .tx_start(tx_start),
    .d_in(d_in), .eop_req(eop_req), .stuff_en(stuff_en),
    .pause(b_pause), .tx_active(b_act), .eop_done(b_done),
    .d_plus(b_dp), .d_minus(b_dm), .ones_cnt(b_ones)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One bit slot: inputs set at negedge, outputs sampled 1 time unit after posedge.
  task automatic slot(input logic d, input logic e);
    @(negedge clk);
    bit_strobe = 1'b1;
    d_in       = d;
    eop_req    = e;
    @(posedge clk);
    #1;
    bit_strobe = 1'b0;
    eop_req    = 1'b0;
  endtask

  task automatic start_pkt();
    @(negedge clk);
    tx_start = 1'b1;
    @(posedge clk);
    #1;
    tx_start = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    n_rst = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_line", {a_dp, a_dm}, LJ);
    chk("rst_act", a_act, 1'b0);
    chk("rst_pause", a_pause, 1'b0);
    chk("rst_done", a_done, 1'b0);
    chk("rst_ones", a_ones, 4'd0);
    n_rst = 1'b1;

    // Strobes in IDLE are ignored
    slot(1'b0, 1'b0);
    chk("idle_strobe_line", {a_dp, a_dm}, LJ);
    chk("idle_strobe_act", a_act, 1'b0);

    start_pkt();
    chk("start_act", a_act, 1'b1);
    chk("start_line", {a_dp, a_dm}, LJ);

    // SYNC 0000000 1 then 0
    for (int i = 0; i < 7; i++) begin
      slot(1'b0, 1'b0);
      chk("sync_line", {a_dp, a_dm}, (i % 2 == 0) ? LK : LJ);
    end
    slot(1'b1, 1'b0);
    chk("sync_one_line", {a_dp, a_dm}, LK);
    chk("sync_one_ones", a_ones, 4'd1);
    slot(1'b0, 1'b0);
    chk("after_sync_line", {a_dp, a_dm}, LJ);
    chk("after_sync_ones", a_ones, 4'd0);

    // Six ones -> stuff slot -> 0
    for (int i = 1; i <= 6; i++) begin
      slot(1'b1, 1'b0);
      chk("run_line", {a_dp, a_dm}, LJ);
      chk("run_ones", a_ones, 32'(i));
      chk("run_pause", a_pause, (i == 6) ? 1'b1 : 1'b0);
    end
    @(negedge clk);
    chk("pause_hold", a_pause, 1'b1);
    slot(1'b1, 1'b0);
    chk("stuff_line", {a_dp, a_dm}, LK);
    chk("stuff_pause", a_pause, 1'b0);
    chk("stuff_ones", a_ones, 4'd0);
    slot(1'b0, 1'b0);
    chk("post_stuff_line", {a_dp, a_dm}, LJ);

    // Five ones then EOP: no stuff, 2 SE0, 1 J
    for (int i = 1; i <= 5; i++) begin
      slot(1'b1, 1'b0);
    end
    chk("pre_eop_ones", a_ones, 4'd5);
    slot(1'b1, 1'b1);
    chk("eop_se0_1", {a_dp, a_dm}, LSE0);
    chk("eop_pause", a_pause, 1'b0);
    chk("eop_ones", a_ones, 4'd0);
    slot(1'b0, 1'b0);
    chk("eop_se0_2", {a_dp, a_dm}, LSE0);
    slot(1'b0, 1'b0);
    chk("eop_j", {a_dp, a_dm}, LJ);
    chk("eop_j_act", a_act, 1'b1);
    chk("eop_j_done", a_done, 1'b0);
    slot(1'b0, 1'b0);
    chk("idle_done", a_done, 1'b1);
    chk("idle_act", a_act, 1'b0);
    chk("idle_line", {a_dp, a_dm}, LJ);
    // tx_start coinciding with eop_done is ignored
    start_pkt();
    chk("done_pulse", a_done, 1'b0);
    chk("start_on_done_ignored", a_act, 1'b0);

    // Asynchronous reset mid-DATA with line at K
    start_pkt();
    slot(1'b0, 1'b0);
    chk("pre_rst_line", {a_dp, a_dm}, LK);
    #2;
    n_rst = 1'b0;
    #1;
    chk("async_rst_line", {a_dp, a_dm}, LJ);
    chk("async_rst_act", a_act, 1'b0);
    chk("async_rst_pause", a_pause, 1'b0);
    @(negedge clk);
    n_rst = 1'b1;

    // Stuffing disabled: twenty ones, no pause, saturating counter
    stuff_en = 1'b0;
    start_pkt();
    for (int i = 1; i <= 20; i++) begin
      slot(1'b1, 1'b0);
      chk("nostuff_pause", a_pause, 1'b0);
      chk("nostuff_line", {a_dp, a_dm}, LJ);
      chk("nostuff_ones", a_ones, (i > 15) ? 32'd15 : 32'(i));
    end
    stuff_en = 1'b1;

    // RUN_LEN=3, EOP_SE0_BITS=3 instance
    do_reset();
    start_pkt();
    chk("b_start_act", b_act, 1'b1);
    for (int i = 1; i <= 3; i++) begin
      slot(1'b1, 1'b0);
      chk("b_run_ones", b_ones, 32'(i));
      chk("b_run_line", {b_dp, b_dm}, LJ);
    end
    chk("b_pause", b_pause, 1'b1);
    slot(1'b1, 1'b0);
    chk("b_stuff_ones", b_ones, 4'd0);
    chk("b_stuff_line", {b_dp, b_dm}, LK);
    chk("b_stuff_pause", b_pause, 1'b0);
    slot(1'b1, 1'b0);
    chk("b_fourth_ones", b_ones, 4'd1);
    chk("b_fourth_line", {b_dp, b_dm}, LK);
    slot(1'b0, 1'b1);
    chk("b_se0_1", {b_dp, b_dm}, LSE0);
    slot(1'b0, 1'b0);
    chk("b_se0_2", {b_dp, b_dm}, LSE0);
    slot(1'b0, 1'b0);
    chk("b_se0_3", {b_dp, b_dm}, LSE0);
    slot(1'b0, 1'b0);
    chk("b_eop_j", {b_dp, b_dm}, LJ);
    chk("b_eop_j_act", b_act, 1'b1);
    slot(1'b0, 1'b0);
    chk("b_done", b_done, 1'b1);
    chk("b_act_low", b_act, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/usb_tx_line_encoder.md
Name: usb_tx_line_encoder

Overview:
Parametrised USB transmit line encoder. It succeeds the fixed six-ones bit stuffer with a single block that does bit stuffing, NRZI encoding, differential D+/D- drive, and EOP generation. It sits between the TX shift register, which supplies one serial bit per bit strobe, and the transceiver pads. The stuff run length and EOP length are parameters, and stuffing can be disabled at run time for test.

Parameters:
RUN_LEN, 6, number of consecutive 1s after which one 0 is inserted (legal 2..15).
CNT_W, 4, width of the ones counter; must satisfy 2^CNT_W > RUN_LEN.
EOP_SE0_BITS, 2, number of SE0 bit times in EOP (legal 1..3).

Ports:
clk  in  1  system clock.
n_rst  in  1  asynchronous active-low reset.
bit_strobe  in  1  one-cycle pulse marking each USB bit slot; all state changes occur only on strobe cycles, except tx_start.
tx_start  in  1  one-cycle pulse; begins a packet when idle, ignored otherwise.
d_in  in  1  next data bit from the shift register, sampled on bit_strobe in DATA.
eop_req  in  1  level; when high on a DATA strobe, that slot begins EOP and d_in is ignored.
stuff_en  in  1  1 = normal stuffing, 0 = stuffing suppressed (test mode).
pause  out  1  high while the current slot is a stuff bit; the shift register must not advance.
tx_active  out  1  high from packet start through the final J bit of EOP.
eop_done  out  1  one-cycle pulse on return to IDLE.
d_plus  out  1  encoded D+.
d_minus  out  1  encoded D-.
ones_cnt  out  CNT_W  current run of consecutive 1s (debug/verification).

Behaviour:
- Reset (async, n_rst=0): state IDLE, d_plus=1, d_minus=0 (J), pause=0, tx_active=0, eop_done=0, ones_cnt=0, NRZI level register=1. Reset mid-packet aborts immediately to these values.
- All outputs are registered. A line change appears in the cycle after the strobe that causes it.
- States: IDLE, DATA, STUFF, EOP_SE0, EOP_J.
- IDLE:
  - Drive J.
  - tx_start -> DATA, tx_active=1, ones_cnt=0, NRZI level=1.
  - Strobes in IDLE are ignored.
- DATA, on bit_strobe with eop_req=0:
  - d_in=0: toggle NRZI level, ones_cnt=0.
  - d_in=1: hold level, ones_cnt+1.
  - If stuff_en=1 and the new ones_cnt==RUN_LEN -> STUFF, pause=1.
  - If stuff_en=0, ones_cnt saturates at 2^CNT_W-1 and STUFF is never entered.
- STUFF, on bit_strobe:
  - Toggle NRZI level (inserted 0), ones_cnt=0, pause=0, return to DATA.
  - eop_req is not honoured during STUFF; it is evaluated on the following DATA strobe.
- DATA, on bit_strobe with eop_req=1:
  - -> EOP_SE0, d_plus=d_minus=0, SE0 slot counter=1, ones_cnt=0.
  - A pending stuff never coexists with this, because STUFF is entered first.
- EOP_SE0, on bit_strobe:
  - If the SE0 counter==EOP_SE0_BITS -> EOP_J, drive J.
  - Otherwise increment the counter and hold SE0.
- EOP_J, on bit_strobe:
  - -> IDLE, tx_active=0, eop_done=1 for one cycle, hold J.
- Line mapping in DATA/STUFF: d_plus=level, d_minus=~level.
- pause is high for exactly one bit slot: from the cycle after the completing strobe through the stuff strobe cycle.
- tx_start is ignored outside IDLE. A tx_start coinciding with eop_done is ignored.

Test Plan:
- Reset then idle: n_rst low mid-DATA with line at K -> d_plus=1, d_minus=0, tx_active=0, pause=0 within the same cycle as n_rst low.
- SYNC 00000001 then data bit 0 -> line toggles K,J,K,J,K,J,K then holds K for the 1, then toggles to J; ones_cnt ends 0.
- RUN_LEN=6, six 1s then 0 -> pause=1 for one slot after the 6th strobe, stuff slot toggles the line, and the shift register's 7th bit (0) toggles again; 8 strobes total.
- Override RUN_LEN=3 with bits 1111 -> stuff after the 3rd 1, 4th 1 sent next; ones_cnt reads 1,2,3,0,1.
- stuff_en=0 with twenty 1s -> pause never asserts, line constant for 20 slots, ones_cnt saturates at 15.
- eop_req raised on the strobe after 5 ones (RUN_LEN=6) -> no stuff, 2 SE0 slots (d_plus=d_minus=0), 1 J slot, eop_done pulse, tx_active falls; with EOP_SE0_BITS=3 -> 3 SE0 slots.
